// File: rtl/tx_seq_pkg.sv
// Shared definitions for the 1553 transmit word sequencer.
//   state_t       : sequencer FSM states
//   WORD_CSW/DW   : type flag stored with each queued word
//   BUSY_TIMEOUT  : cycles allowed for the encoder to raise tx_busy
//   fifo_entry_t  : one queued word plus its type flag
package tx_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic WORD_CSW = 1'b1;
  localparam logic WORD_DW  = 1'b0;

  localparam int BUSY_TIMEOUT = 2;

  typedef struct packed {
    logic        csw;   // 1 = command/status, 0 = data
    logic [0:15] word;  // bit 0 is first on the wire
  } fifo_entry_t;

endpackage

// File: rtl/tx_word_fifo.sv
// Synchronous word FIFO (17 bits: type flag + word), DEPTH entries.
//   push/din : enqueue when not full (dropped when full)
//   pop      : dequeue head when not empty
//   clr      : discard all contents; overrides push and pop
//   dout     : current head entry (valid when !empty)
//   full/empty/count : occupancy, count saturates at DEPTH
module tx_word_fifo
  import tx_seq_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          enc_clk,
  input  logic          rst_n,
  input  logic          push,
  input  fifo_entry_t   din,
  input  logic          pop,
  input  logic          clr,
  output fifo_entry_t   dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; pointers/count define validity.
  always_ff @(posedge enc_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tx_word_sequencer.sv
// Upstream stage of the 1553 encoder. Buffers host words and, on
// msg_start, hands them to the encoder one at a time, pacing on tx_busy.
//   host side   : wr_en/wr_word/wr_csw in, wr_full/wr_count/wr_ovf out
//   control     : msg_start, flush in; msg_busy/msg_done/tx_err out
//   encoder     : tx_dword + one-cycle tx_csw/tx_dw strobe out, tx_busy in
// All outputs are registered. The strobe is visible during the ISSUE
// state cycle; the head is popped on the edge that enters ISSUE.
module tx_word_sequencer
  import tx_seq_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          enc_clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [0:15]   wr_word,
  input  logic          wr_csw,
  output logic          wr_full,
  output logic [AW:0]   wr_count,
  output logic          wr_ovf,
  input  logic          msg_start,
  input  logic          flush,
  output logic [0:15]   tx_dword,
  output logic          tx_csw,
  output logic          tx_dw,
  input  logic          tx_busy,
  output logic          msg_busy,
  output logic          msg_done,
  output logic          tx_err
);

  state_t      state, state_nxt;
  logic [1:0]  wait_cnt;
  logic        issue, timeout, f_clr;
  logic        f_full, f_empty;
  fifo_entry_t head, wr_ent;

  assign wr_ent = '{csw: wr_csw, word: wr_word};

  tx_word_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .enc_clk (enc_clk),
    .rst_n   (rst_n),
    .push    (wr_en),
    .din     (wr_ent),
    .pop     (issue),
    .clr     (f_clr),
    .dout    (head),
    .full    (f_full),
    .empty   (f_empty),
    .count   (wr_count)
  );

  assign wr_full = f_full;

  // Flush has top priority: because the strobe is registered on entry to
  // ISSUE, a flush sampled on that edge cancels both the pop and strobe.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    timeout   = 1'b0;
    f_clr     = flush;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (msg_start && !f_empty) begin
          state_nxt = ISSUE;
          issue     = 1'b1;
        end
        ISSUE: state_nxt = WAIT_HI;
        WAIT_HI: begin
          if (tx_busy) begin
            state_nxt = WAIT_LO;
          end else if (wait_cnt == 2'(BUSY_TIMEOUT - 1)) begin
            // Encoder never acknowledged: drop the rest of the message.
            timeout   = 1'b1;
            f_clr     = 1'b1;
            state_nxt = IDLE;
          end
        end
        WAIT_LO: if (!tx_busy) begin
          if (!f_empty) begin
            state_nxt = ISSUE;
            issue     = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      tx_dword <= '0;
      tx_csw   <= 1'b0;
      tx_dw    <= 1'b0;
      msg_busy <= 1'b0;
      msg_done <= 1'b0;
      tx_err   <= 1'b0;
      wr_ovf   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT_HI) ? wait_cnt + 1'b1 : 2'd0;
      tx_csw   <= issue && (head.csw == WORD_CSW);
      tx_dw    <= issue && (head.csw == WORD_DW);
      if (flush)      tx_dword <= '0;
      else if (issue) tx_dword <= head.word;
      msg_busy <= (state_nxt != IDLE);
      msg_done <= (state_nxt == DONE);
      tx_err   <= timeout;
      wr_ovf   <= wr_en && f_full && !flush;
    end
  end

endmodule

// File: tb/tb_tx_word_sequencer.sv
module tb_tx_word_sequencer;

  logic        enc_clk = 1'b0;
  logic        rst_n;
  logic        wr_en, wr_csw, msg_start, flush, tx_busy;
  logic [0:15] wr_word, tx_dword;
  logic        wr_full, wr_ovf, tx_csw, tx_dw, msg_busy, msg_done, tx_err;
  logic [6:0]  wr_count;

  int total = 0;
  int bad   = 0;

  // Encoder model: busy for 39 cycles after sampling a strobe.
  logic enc_en;
  int   enc_cnt;
  always @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n)                enc_cnt <= 0;
    else if (tx_csw || tx_dw)  enc_cnt <= 39;
    else if (enc_cnt > 0)      enc_cnt <= enc_cnt - 1;
  end
  assign tx_busy = enc_en && (enc_cnt != 0);

  always #5 enc_clk = ~enc_clk;

  tx_word_sequencer #(.DEPTH(64), .AW(6)) dut (
    .enc_clk(enc_clk), .rst_n(rst_n), .wr_en(wr_en), .wr_word(wr_word),
    .wr_csw(wr_csw), .wr_full(wr_full), .wr_count(wr_count), .wr_ovf(wr_ovf),
    .msg_start(msg_start), .flush(flush), .tx_dword(tx_dword),
    .tx_csw(tx_csw), .tx_dw(tx_dw), .tx_busy(tx_busy), .msg_busy(msg_busy),
    .msg_done(msg_done), .tx_err(tx_err)
  );

  task push_word(input logic csw, input logic [15:0] w);
    wr_en = 1'b1; wr_csw = csw; wr_word = w;
    @(negedge enc_clk);
    wr_en = 1'b0;
  endtask

  task test_reset();
    #12;
    total++; if ({tx_dword, tx_csw, tx_dw, msg_busy, msg_done, tx_err, wr_ovf, wr_full} !== 24'h0) begin
      bad++; $display("FAIL reset_outs got tx_dword=%h strobes=%b%b busy=%b", tx_dword, tx_csw, tx_dw, msg_busy); end
    total++; if (wr_count !== 7'd0) begin bad++; $display("FAIL reset_count got %0d want 0", wr_count); end
    @(negedge enc_clk); rst_n = 1'b1;
  endtask

  task test_basic();
    int n;
    repeat (50) @(negedge enc_clk);
    enc_en = 1'b1;
    push_word(1'b1, 16'h1234);
    push_word(1'b0, 16'hABCD);
    total++; if (wr_count !== 7'd2) begin bad++; $display("FAIL basic_count got %0d want 2", wr_count); end
    msg_start = 1'b1; @(negedge enc_clk); msg_start = 1'b0;
    total++; if ({tx_csw, tx_dw} !== 2'b10 || tx_dword !== 16'h1234) begin
      bad++; $display("FAIL basic_csw got csw/dw=%b%b word=%h want 10 1234", tx_csw, tx_dw, tx_dword); end
    total++; if (msg_busy !== 1'b1) begin bad++; $display("FAIL basic_busy got %b want 1", msg_busy); end
    for (n = 1; n <= 100; n++) begin
      @(negedge enc_clk);
      if (tx_dw || tx_csw) break;
    end
    total++; if (n !== 41 || tx_dw !== 1'b1 || tx_dword !== 16'hABCD) begin
      bad++; $display("FAIL basic_dw got spacing=%0d dw=%b word=%h want 41 1 abcd", n, tx_dw, tx_dword); end
    for (n = 0; n < 60; n++) begin
      @(negedge enc_clk);
      if (!tx_busy) break;
    end
    total++; if (n >= 60 || msg_done !== 1'b0) begin
      bad++; $display("FAIL basic_busyfall got n=%0d done=%b want busy fall, done 0", n, msg_done); end
    @(negedge enc_clk);
    total++; if (msg_done !== 1'b1) begin bad++; $display("FAIL basic_done got %b want 1", msg_done); end
    @(negedge enc_clk);
    total++; if (msg_done !== 1'b0 || msg_busy !== 1'b0 || wr_count !== 7'd0) begin
      bad++; $display("FAIL basic_end got done=%b busy=%b count=%0d want 0 0 0", msg_done, msg_busy, wr_count); end
  endtask

  task test_overflow();
    repeat (50) @(negedge enc_clk);
    for (int i = 0; i < 64; i++) begin
      push_word(1'b0, 16'(i + 1));
      if (i == 62) begin
        total++; if (wr_full !== 1'b0) begin bad++; $display("FAIL ovf_full63 got %b want 0", wr_full); end
      end
    end
    total++; if (wr_full !== 1'b1 || wr_count !== 7'd64 || wr_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_full64 got full=%b count=%0d ovf=%b want 1 64 0", wr_full, wr_count, wr_ovf); end
    push_word(1'b0, 16'hFFFF);
    total++; if (wr_ovf !== 1'b1 || wr_count !== 7'd64) begin
      bad++; $display("FAIL ovf_pulse got ovf=%b count=%0d want 1 64", wr_ovf, wr_count); end
    @(negedge enc_clk);
    total++; if (wr_ovf !== 1'b0) begin bad++; $display("FAIL ovf_once got %b want 0", wr_ovf); end
    // flush with simultaneous write: write dropped, no overflow
    flush = 1'b1; wr_en = 1'b1; wr_word = 16'h5555; wr_csw = 1'b0;
    @(negedge enc_clk); flush = 1'b0; wr_en = 1'b0;
    total++; if (wr_count !== 7'd0 || wr_full !== 1'b0 || wr_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_flush got count=%0d full=%b ovf=%b want 0 0 0", wr_count, wr_full, wr_ovf); end
  endtask

  task test_timeout();
    int strobes;
    repeat (50) @(negedge enc_clk);
    enc_en = 1'b0;
    push_word(1'b1, 16'h0C01);
    push_word(1'b0, 16'h0D02);
    push_word(1'b0, 16'h0D03);
    msg_start = 1'b1; @(negedge enc_clk); msg_start = 1'b0;
    total++; if ({tx_csw, tx_dw} !== 2'b10 || tx_dword !== 16'h0C01) begin
      bad++; $display("FAIL to_strobe got %b%b word=%h want 10 0c01", tx_csw, tx_dw, tx_dword); end
    strobes = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge enc_clk);
      if (tx_csw || tx_dw) strobes++;
      if (i < 3) begin
        total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL to_early cycle %0d got err=%b want 0", i, tx_err); end
      end
    end
    total++; if (tx_err !== 1'b1 || msg_busy !== 1'b0 || wr_count !== 7'd0) begin
      bad++; $display("FAIL to_err got err=%b busy=%b count=%0d want 1 0 0", tx_err, msg_busy, wr_count); end
    @(negedge enc_clk);
    total++; if (tx_err !== 1'b0 || strobes !== 0) begin
      bad++; $display("FAIL to_after got err=%b extra strobes=%0d want 0 0", tx_err, strobes); end
  endtask

  task test_flush();
    int strobes, dones;
    repeat (50) @(negedge enc_clk);
    enc_en = 1'b1;
    push_word(1'b1, 16'h2001);
    for (int i = 0; i < 4; i++) push_word(1'b0, 16'(16'h3000 + i));
    msg_start = 1'b1; @(negedge enc_clk); msg_start = 1'b0;
    repeat (5) @(negedge enc_clk);  // now in WAIT_LO, encoder busy
    total++; if (wr_count !== 7'd4 || tx_busy !== 1'b1) begin
      bad++; $display("FAIL fl_pre got count=%0d busy=%b want 4 1", wr_count, tx_busy); end
    flush = 1'b1; @(negedge enc_clk); flush = 1'b0;
    total++; if (tx_dword !== 16'h0 || wr_count !== 7'd0 || msg_busy !== 1'b0) begin
      bad++; $display("FAIL fl_state got word=%h count=%0d busy=%b want 0 0 0", tx_dword, wr_count, msg_busy); end
    strobes = 0; dones = 0;
    repeat (60) begin
      @(negedge enc_clk);
      if (tx_csw || tx_dw) strobes++;
      if (msg_done) dones++;
    end
    total++; if (strobes !== 0 || dones !== 0) begin
      bad++; $display("FAIL fl_quiet got strobes=%0d dones=%0d want 0 0", strobes, dones); end
  endtask

  task test_push_pop();
    int n, strobes, dones;
    repeat (50) @(negedge enc_clk);
    enc_en = 1'b1;
    push_word(1'b1, 16'h1111);
    msg_start = 1'b1; wr_en = 1'b1; wr_csw = 1'b0; wr_word = 16'h2222;
    @(negedge enc_clk); msg_start = 1'b0; wr_en = 1'b0;
    total++; if (wr_count !== 7'd1 || tx_csw !== 1'b1 || tx_dword !== 16'h1111) begin
      bad++; $display("FAIL pp_first got count=%0d csw=%b word=%h want 1 1 1111", wr_count, tx_csw, tx_dword); end
    strobes = 1; dones = 0;
    for (n = 1; n <= 100; n++) begin
      @(negedge enc_clk);
      if (tx_csw || tx_dw) break;
    end
    total++; if (n !== 41 || tx_dw !== 1'b1 || tx_dword !== 16'h2222) begin
      bad++; $display("FAIL pp_second got spacing=%0d dw=%b word=%h want 41 1 2222", n, tx_dw, tx_dword); end
    if (n <= 100) strobes++;
    repeat (60) begin
      @(negedge enc_clk);
      if (tx_csw || tx_dw) strobes++;
      if (msg_done) dones++;
    end
    total++; if (strobes !== 2 || dones !== 1 || msg_busy !== 1'b0) begin
      bad++; $display("FAIL pp_total got strobes=%0d dones=%0d busy=%b want 2 1 0", strobes, dones, msg_busy); end
  endtask

  task test_reset_mid();
    int evts;
    repeat (50) @(negedge enc_clk);
    enc_en = 1'b1;
    push_word(1'b1, 16'h4321);
    push_word(1'b0, 16'h8765);
    msg_start = 1'b1; @(negedge enc_clk); msg_start = 1'b0;
    @(negedge enc_clk);  // WAIT_HI
    total++; if (tx_dword !== 16'h4321 || msg_busy !== 1'b1) begin
      bad++; $display("FAIL rm_pre got word=%h busy=%b want 4321 1", tx_dword, msg_busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({tx_dword, tx_csw, tx_dw, msg_busy, msg_done, tx_err, wr_ovf, wr_full} !== 24'h0 || wr_count !== 7'd0) begin
      bad++; $display("FAIL rm_async got word=%h busy=%b count=%0d want all 0", tx_dword, msg_busy, wr_count); end
    @(negedge enc_clk); rst_n = 1'b1;
    msg_start = 1'b1; @(negedge enc_clk); msg_start = 1'b0;
    evts = 0;
    repeat (5) begin
      if (tx_csw || tx_dw || msg_done || tx_err || msg_busy) evts++;
      @(negedge enc_clk);
    end
    total++; if (evts !== 0 || msg_busy !== 1'b0) begin
      bad++; $display("FAIL rm_idle got events=%0d busy=%b want 0 0", evts, msg_busy); end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_csw = 1'b0; wr_word = '0;
    msg_start = 1'b0; flush = 1'b0; enc_en = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_timeout();
    test_flush();
    test_push_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
